word_byte_serializer: RTL
=========================

Name: word_byte_serializer

Overview:
- Parametrised successor to the fixed 64-to-8 byte selector.
- Accepts a WORD_BYTES-wide word with a valid/ready handshake and a per-word byte count, then emits that many bytes one per accepted cycle on a byte-wide valid/ready stream.
- Byte order is selectable.
- Sits between the event/timestamp capture logic and the byte-oriented host/UART/FIFO path of the transition logger.

Parameters:
WORD_BYTES, 8, number of bytes in in_word; legal values are 2 to 32
MSB_FIRST, 0, 0 = emit byte 0 (in_word[7:0]) first; 1 = emit highest selected byte first
LW, $clog2(WORD_BYTES)+1, width of in_nbytes; derived, not to be overridden

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort; drops the word in progress
in_word  input  WORD_BYTES*8  word to serialize
in_nbytes  input  LW  bytes to send, 1..WORD_BYTES; 0 or >WORD_BYTES is treated as WORD_BYTES
in_valid  input  1  in_word/in_nbytes valid
in_ready  output  1  serializer can accept a word this cycle
out_byte  output  8  current byte
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts out_byte this cycle
out_last  output  1  out_byte is the final byte of the word
busy  output  1  a word is held (state SEND)

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is asynchronous, active-high.
  - While reset is high: state=IDLE, held word=0, count=0, idx=0, out_byte=8'h00, out_valid=0, out_last=0, busy=0, in_ready=0.
  - in_ready rises in the first cycle after reset deasserts.
- Registers: held word (WORD_BYTES*8), count n (LW), index idx (LW), state (IDLE/SEND).
- Handshake:
  - A word transfer occurs when in_valid && in_ready.
  - A byte transfer occurs when out_valid && out_ready.
- in_ready is combinational: !reset && !flush && (state==IDLE || (state==SEND && out_ready && out_last)).
  - Back-to-back words therefore have no bubble.
  - The out_ready->in_ready combinational path is intentional and must be documented at integration.
- IDLE state:
  - out_valid=0, out_last=0, out_byte=8'h00, busy=0.
  - On a word transfer: capture in_word and the clamped n, set idx=0, go to SEND.
- SEND state:
  - out_valid=1 and busy=1.
  - out_byte selection:
    - MSB_FIRST=0: byte[idx].
    - MSB_FIRST=1: byte[n-1-idx].
    - byte[k] = held[8k+7:8k].
  - out_last = (idx==n-1).
  - Byte transfer with !out_last: idx <= idx+1.
  - Byte transfer with out_last and a simultaneous word transfer: capture the new word, idx <= 0, stay in SEND.
  - Byte transfer with out_last and no word transfer: go to IDLE; held word is retained, not cleared.
  - No byte transfer: all registers hold; out_byte and out_last stay stable (stall).
- Latency:
  - Word accepted at edge N; first byte presented with out_valid=1 after edge N.
  - With out_ready held high, a word of n bytes occupies exactly n cycles.
  - Throughput: 1 byte/cycle.
- Length rules:
  - MSB_FIRST=1 with n<WORD_BYTES sends the low n bytes only, most significant of those first.
  - Upper bytes are never emitted.
- flush:
  - Highest priority after reset.
  - At the edge where flush is high: state <= IDLE, idx <= 0; no word is captured.
  - in_ready=0 during that cycle.
  - A byte handshake in the flush cycle still counts downstream, but the serializer does not advance.
- Non-SEND states: out_byte is driven from a register or gated to 8'h00; it never carries X.
- Unused state encodings decode to IDLE.

Test Plan:
- Defaults, out_ready=1, in_word=64'h0807060504030201, in_nbytes=8, single in_valid pulse -> out_byte sequence 01,02,...,08 on 8 consecutive cycles; out_last high only with 08; first byte appears the cycle after acceptance; then IDLE with in_ready=1.
- MSB_FIRST=1, WORD_BYTES=8, in_word=64'hAABBCCDD11223344, in_nbytes=3 -> bytes 22,33,44; out_last with 44; AA..11 never emitted.
- Back-to-back: in_valid held high with words W0=...01..08 and W1=...11..18, out_ready=1 -> 16 contiguous bytes with no idle cycle; in_ready high exactly in the out_last cycle of W0.
- Backpressure: toggle out_ready 1,0,0,1,... during a word with in_nbytes=4 -> out_byte and out_last stable while stalled; exactly 4 transfers; in_ready=0 until the last transfer.
- in_nbytes=0 and in_nbytes=9 (WORD_BYTES=8) -> each treated as 8 bytes; WORD_BYTES=4 build: 32'hDEADBEEF with in_nbytes=4 -> EF,BE,AD,DE.
- flush asserted after the 2nd byte of an 8-byte word -> next cycle out_valid=0, busy=0, in_ready=1. Async reset asserted mid-word on a non-clock edge -> outputs zero immediately; in_ready=0 until reset deasserts.

Source files
------------

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: accepts a WORD_BYTES-wide word plus a byte count and
// emits that many bytes, one per accepted cycle, on a byte-wide valid/ready
// stream. Byte order is fixed at build time by MSB_FIRST.
// Latency: a word accepted at edge N presents its first byte after edge N;
// an n-byte word occupies exactly n cycles when out_ready stays high.
// Backpressure: out_ready low freezes all state and holds out_byte/out_last.
// in_ready is combinational from out_ready, so a new word can load in the
// last-byte cycle with no bubble (out_ready -> in_ready is a comb path).
//
// Ports:
//   clk, reset            clock, async active-high reset
//   flush                 synchronous abort of the word in progress
//   in_word/in_nbytes     word and byte count (0 or >WORD_BYTES => WORD_BYTES)
//   in_valid/in_ready     input word handshake
//   out_byte/out_last     current byte and end-of-word marker
//   out_valid/out_ready   output byte handshake
//   busy                  a word is held (SEND state)
module word_byte_serializer #(
  parameter int WORD_BYTES = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int LW         = $clog2(WORD_BYTES) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [WORD_BYTES*8-1:0] in_word,
  input  logic [LW-1:0]           in_nbytes,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int SW = $clog2(WORD_BYTES);
  localparam logic [LW-1:0] WB  = LW'(WORD_BYTES);
  localparam logic [LW-1:0] ONE = LW'(1);

  // Two-bit state register; any encoding other than ST_SEND behaves as idle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;

  logic [1:0]                  state;
  logic [WORD_BYTES-1:0][7:0]  held;
  logic [LW-1:0]               n;
  logic [LW-1:0]               idx;
  logic [LW-1:0]               n_in;
  logic [SW-1:0]               sel;
  logic                        send;
  logic                        word_xfer;

  assign send = (state == ST_SEND);

  // Out-of-range counts mean "whole word".
  assign n_in = ((in_nbytes == '0) || (in_nbytes > WB)) ? WB : in_nbytes;

  // MSB-first walks down from the highest selected byte, so a short word
  // sends its low n bytes only and never exposes the upper ones.
  assign sel = SW'(MSB_FIRST ? (n - ONE - idx) : idx);

  assign out_valid = send;
  assign busy      = send;
  assign out_last  = send && (idx == (n - ONE));
  assign out_byte  = send ? held[sel] : 8'h00;

  assign in_ready  = !reset && !flush &&
                     (!send || (out_ready && out_last));
  assign word_xfer = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      held  <= '0;
      n     <= '0;
      idx   <= '0;
    end else if (flush) begin
      // A byte handshake in this cycle is consumed downstream but not
      // tracked here; the word is simply abandoned.
      state <= ST_IDLE;
      idx   <= '0;
    end else if (word_xfer) begin
      // Covers both the idle load and the back-to-back load on the last byte.
      held  <= in_word;
      n     <= n_in;
      idx   <= '0;
      state <= ST_SEND;
    end else if (send) begin
      if (out_ready) begin
        if (out_last) state <= ST_IDLE;  // held word is kept, not cleared
        else          idx   <= idx + ONE;
      end
    end else begin
      state <= ST_IDLE;  // normalise any stray encoding
    end
  end

endmodule
